// File: rtl/spi_ctrl_bank.sv
// rtl/spi_ctrl_bank.sv - per-channel SPI control words, round-robin dispatch to one shared engine
// Optional feature macro: SPI_CTRL_IRQ_EN (registered irq_o from sticky status bits).
module spi_ctrl_bank #(
  parameter int N_CH      = 4,
  parameter int CNT_WIDTH = 10,
  parameter int AW        = $clog2(N_CH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_i,
  input  logic [AW-1:0]           addr_i,
  input  logic [31:0]             data_i,
  output logic [31:0]             rdata_o,
  output logic                    start_o,
  output logic [$clog2(N_CH)-1:0] ch_o,
  output logic [31:0]             ctrl_o,
  input  logic                    done_i,
  input  logic [CNT_WIDTH-1:0]    n_rx_end_i,
  output logic                    busy_o,
  output logic                    irq_o
);

  localparam int CHW   = $clog2(N_CH);
  localparam int RX_LO = CNT_WIDTH + 2;
  localparam int RX_HI = 2 * CNT_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_ctrl [N_CH];
  logic [N_CH-1:0] r_done;
  logic            r_err;
  logic [CHW-1:0]  r_rr_ptr;
  logic [CHW-1:0]  r_ch;
  logic [31:0]     r_ctrl_o;
  logic [31:0]     r_rdata;

  logic            w_found;
  logic [CHW-1:0]  w_pick;
  logic [31:0]     w_pick_word;
  logic            w_complete;
  logic            w_stat_wr;
  logic            w_collide;
  logic [N_CH-1:0] w_wr_en;
  logic [N_CH-1:0] w_done_clr;
  logic [N_CH-1:0] w_done_set;
  logic [31:0]     w_status;
  logic [31:0]     w_rdata;

  // Pending channel closest to rr_ptr, measured as forward distance modulo N_CH.
  always_comb begin
    int v_off;
    int v_best;
    v_off       = 0;
    v_best      = N_CH;
    w_found     = 1'b0;
    w_pick      = '0;
    w_pick_word = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (r_ctrl[c][0]) begin
        v_off = (c + N_CH - int'(r_rr_ptr)) % N_CH;
        if (v_off < v_best) begin
          v_best      = v_off;
          w_found     = 1'b1;
          w_pick      = CHW'(c);
          w_pick_word = r_ctrl[c];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_BUSY;
      S_BUSY:  if (done_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    start_o = 1'b0;
    busy_o  = 1'b0;
    case (r_state)
      S_ISSUE: start_o = 1'b1;
      S_BUSY:  busy_o  = 1'b1;
      default: ;
    endcase
  end

  assign w_complete = (r_state == S_BUSY) && done_i;
  assign w_stat_wr  = wr_i && (addr_i == AW'(N_CH));
  assign w_collide  = wr_i && busy_o && (addr_i == AW'(r_ch));
  assign w_done_clr = w_stat_wr ? data_i[N_CH-1:0] : '0;

  always_comb begin
    w_wr_en    = '0;
    w_done_set = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_wr_en[c]    = wr_i && (addr_i == AW'(c)) && !(busy_o && (r_ch == CHW'(c)));
      w_done_set[c] = w_complete && (r_ch == CHW'(c));
    end
  end

  always_comb begin
    w_status           = '0;
    w_status[N_CH-1:0] = r_done;
    w_status[31]       = r_err;
  end

  always_comb begin
    w_rdata = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (addr_i == AW'(c)) w_rdata = r_ctrl[c];
    end
    if (addr_i == AW'(N_CH)) w_rdata = w_status;
  end

  // A write to the in-flight word is masked off in w_wr_en, so it never races the write-back.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int c = 0; c < N_CH; c++) r_ctrl[c] <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (w_wr_en[c]) begin
          r_ctrl[c] <= data_i;
        end else if (w_done_set[c]) begin
          r_ctrl[c][0]           <= 1'b0;
          r_ctrl[c][RX_HI:RX_LO] <= n_rx_end_i;
        end
      end
    end
  end

  // Set terms are OR-ed in after the W1C mask so a same-cycle set wins.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_done <= '0;
      r_err  <= 1'b0;
    end else begin
      r_done <= (r_done & ~w_done_clr) | w_done_set;
      r_err  <= (r_err & ~(w_stat_wr && data_i[31])) | w_collide;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rr_ptr <= '0;
      r_ch     <= '0;
      r_ctrl_o <= '0;
      r_rdata  <= '0;
    end else begin
      r_rdata <= w_rdata;
      if (r_state == S_IDLE && w_found) begin
        r_ch     <= w_pick;
        r_ctrl_o <= w_pick_word;
      end
      if (w_complete) begin
        r_rr_ptr <= (r_ch == CHW'(N_CH - 1)) ? '0 : r_ch + CHW'(1);
      end
    end
  end

  assign rdata_o = r_rdata;
  assign ch_o    = r_ch;
  assign ctrl_o  = r_ctrl_o;

`ifdef SPI_CTRL_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_irq <= 1'b0;
    else        r_irq <= (|r_done) | r_err;
  end
  assign irq_o = r_irq;
`else
  assign irq_o = 1'b0;
`endif

endmodule
